// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_WRITE  = 1'b0;
  localparam logic I2C_READ   = 1'b1;
  localparam int   I2C_ADDR_W = 7;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line, plus a history flop for edge detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, hist_q;
  logic sync1_d, sync2_d, hist_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Idle bus is high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~hist_q;
  assign fall  = ~sync2_q & hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: fixed 7-bit address, byte-wide write strobe and read request interface.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync u_scl_sync (.clk(clk), .rst_n(rst_n), .din(scl),
                            .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda_sync (.clk(clk), .rst_n(rst_n), .din(sda_in),
                            .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  i2c_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;
  logic       rack_q, rack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    rack_d     = rack_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;

    if (stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else if (start) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd7;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        // Bits are counted on the rising edge so the SCL fall that follows
        // a START is not mistaken for the end of a bit.
        ST_ADDR, ST_WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            if (cnt_q == 3'd0) done_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            cnt_d  = 3'd7;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == ADDR) begin
                sda_oe_d = 1'b1;
                state_d  = ST_ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_IGNORE;
              end
            end else begin
              wr_valid_d = 1'b1;
              wr_data_d  = shift_q;
              sda_oe_d   = 1'b1;
              state_d    = ST_WRITE_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (shift_q[0] == I2C_READ) begin
              rd_req_d = 1'b1;
              state_d  = ST_READ;
            end else begin
              state_d  = ST_WRITE;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
          end
        end
        // rd_data is sampled during the rd_req cycle itself.
        ST_READ: begin
          if (rd_req_q) begin
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end else if (scl_rise) begin
            if (cnt_q == 3'd0) done_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = ST_READ_ACK;
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            rack_d = sda_lvl;
          end else if (scl_fall) begin
            if (!rack_q) begin
              rd_req_d = 1'b1;
              cnt_d    = 3'd7;
              state_d  = ST_READ;
            end else begin
              state_d  = ST_IGNORE;
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default:   state_d  = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= 8'h00;
      done_q     <= 1'b0;
      rack_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      rack_q     <= rack_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: a bit-banged I2C master drives i2c_target over an open-drain SDA model.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam time TCLK = 10;
  localparam time Q    = 8 * TCLK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       sda_wire;

  int tests = 0;
  int fails = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  int both_cnt = 0;
  logic [7:0] wr_last = 8'h00;

  assign sda_wire = sda_m & ~sda_oe;

  i2c_target #(.ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_wire),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
  );

  always #(TCLK/2) clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= wr_data;
    end
    if (rd_req) rd_cnt <= rd_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (wr_valid && rd_req) both_cnt <= both_cnt + 1;
  end

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q; #Q;
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    seen = sda_wire; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(master_ack, s);
  endtask

  task automatic test_reset();
    #(3*TCLK + 3); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({sda_oe, wr_valid, wr_data, rd_req, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got oe=%b wv=%b wd=%h rr=%b busy=%b, want all 0",
               sda_oe, wr_valid, wr_data, rd_req, busy);
    end
  endtask

  task automatic test_write();
    logic ack_a, ack_d;
    int wr0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack_a);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    write_byte(8'hA5, ack_d);
    bus_stop();
    tests++;
    if ({ack_a, ack_d} !== 2'b00) begin fails++; $display("FAIL write_acks: got %b want 00", {ack_a, ack_d}); end
    tests++;
    if (wr_cnt - wr0 != 1) begin fails++; $display("FAIL write_count: got %0d want 1", wr_cnt - wr0); end
    tests++;
    if (wr_last !== 8'hA5) begin fails++; $display("FAIL write_data: got %h want a5", wr_last); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic ack_a, ack_d;
    int wr0 = wr_cnt;
    int oe0 = oe_cnt;
    bus_start();
    write_byte(8'hA2, ack_a);
    write_byte(8'hFF, ack_d);
    tests++;
    if (dut.state_q !== ST_IGNORE) begin fails++; $display("FAIL nomatch_state: got %0d want %0d", dut.state_q, ST_IGNORE); end
    bus_stop();
    tests++;
    if (oe_cnt != oe0 || {ack_a, ack_d} !== 2'b11) begin
      fails++; $display("FAIL nomatch_oe: got oe cycles %0d acks %b want 0 and 11", oe_cnt - oe0, {ack_a, ack_d});
    end
    tests++;
    if (wr_cnt != wr0) begin fails++; $display("FAIL nomatch_wr: got %0d strobes want 0", wr_cnt - wr0); end
    tests++;
    if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL nomatch_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_read();
    logic ack_a;
    logic [7:0] d0, d1;
    int rd0 = rd_cnt;
    rd_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, ack_a);
    tests++;
    if (ack_a !== 1'b0) begin fails++; $display("FAIL read_addr_ack: got %b want 0", ack_a); end
    for (int i = 7; i >= 0; i--) begin
      logic s;
      bus_bit(1'b1, s);
      d0[i] = s;
    end
    rd_data = 8'hC3;
    begin logic s; bus_bit(1'b0, s); end
    read_byte(1'b1, d1);
    tests++;
    if (sda_oe !== 1'b0) begin fails++; $display("FAIL read_nack_oe: got %b want 0", sda_oe); end
    bus_stop();
    tests++;
    if (d0 !== 8'h3C) begin fails++; $display("FAIL read_byte0: got %h want 3c", d0); end
    tests++;
    if (d1 !== 8'hC3) begin fails++; $display("FAIL read_byte1: got %h want c3", d1); end
    tests++;
    if (rd_cnt - rd0 != 2) begin fails++; $display("FAIL read_req_count: got %0d want 2", rd_cnt - rd0); end
  endtask

  task automatic test_restart();
    logic ack_a, ack_r, s;
    logic [7:0] d;
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    rd_data = 8'h96;
    bus_start();
    write_byte(8'hA0, ack_a);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
    bus_start();
    write_byte(8'hA1, ack_r);
    tests++;
    if (rd_cnt - rd0 != 1) begin fails++; $display("FAIL restart_first_req: got %0d want 1", rd_cnt - rd0); end
    read_byte(1'b1, d);
    bus_stop();
    tests++;
    if (wr_cnt != wr0) begin fails++; $display("FAIL restart_no_wr: got %0d strobes want 0", wr_cnt - wr0); end
    tests++;
    if ({ack_a, ack_r} !== 2'b00 || d !== 8'h96) begin
      fails++; $display("FAIL restart_read: got acks %b data %h want 00 96", {ack_a, ack_r}, d);
    end
  endtask

  task automatic test_stop_mid_byte();
    logic ack_a, ack_b, ack_c, s;
    int wr0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack_a);
    bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
    bus_stop();
    tests++;
    if (wr_cnt != wr0 || sda_oe !== 1'b0 || busy !== 1'b0 || dut.state_q !== ST_IDLE) begin
      fails++; $display("FAIL stop_mid: got wr %0d oe %b busy %b state %0d want 0 0 0 %0d",
                        wr_cnt - wr0, sda_oe, busy, dut.state_q, ST_IDLE);
    end
    bus_start();
    write_byte(8'hA0, ack_b);
    write_byte(8'h12, ack_c);
    bus_stop();
    tests++;
    if ({ack_b, ack_c} !== 2'b00 || wr_cnt - wr0 != 1 || wr_last !== 8'h12) begin
      fails++; $display("FAIL stop_recover: got acks %b wr %0d data %h want 00 1 12",
                        {ack_b, ack_c}, wr_cnt - wr0, wr_last);
    end
  endtask

  task automatic test_async_reset();
    logic s, ack_b, ack_c;
    int wr0;
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'hA0;
      bus_bit(a[i], s);
    end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    tests++;
    if (sda_oe !== 1'b1) begin fails++; $display("FAIL arst_pre_ack: got %b want 1", sda_oe); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sda_oe, wr_valid, wr_data, rd_req, busy} !== 12'h000) begin
      fails++; $display("FAIL arst_outputs: got oe=%b wv=%b wd=%h rr=%b busy=%b want all 0",
                        sda_oe, wr_valid, wr_data, rd_req, busy);
    end
    #(3*TCLK); rst_n = 1'b1;
    #Q; scl = 1'b0; #Q;
    bus_stop();
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack_b);
    write_byte(8'h5A, ack_c);
    bus_stop();
    tests++;
    if ({ack_b, ack_c} !== 2'b00 || wr_cnt - wr0 != 1 || wr_last !== 8'h5A) begin
      fails++; $display("FAIL arst_recover: got acks %b wr %0d data %h want 00 1 5a",
                        {ack_b, ack_c}, wr_cnt - wr0, wr_last);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_restart();
    test_stop_mid_byte();
    test_async_reset();
    tests++;
    if (both_cnt != 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
